// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   LEN_W   : width of the little-endian program length prefix (words).
//   LANE_W  : width of the byte-lane index within a 32-bit word.
//   state_t : loader FSM states (3-bit encoding).
package loader_pkg;

  localparam int LEN_W  = 16;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
//   clk, rst   : clock, synchronous active-high reset.
//   byte_data  : incoming byte.
//   accept     : byte_data is consumed this cycle.
//   clear      : discard any partial word and restart at lane 0.
//   lane       : lane the next accepted byte will occupy.
//   word       : packed word, including the byte accepted this cycle.
//   word_done  : pulse on the cycle the 4th byte of a word is accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              accept,
  input  logic              clear,
  output logic [LANE_W-1:0] lane,
  output logic [31:0]       word,
  output logic              word_done
);

  logic [31:0] word_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane   <= '0;
      word_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (lane == LANE_W'(k)) word_q[8*k +: 8] <= byte_data;
      end
      lane <= lane + LANE_W'(1);
    end
  end

  // The word is exposed with the current byte merged in, so the loader can
  // capture a complete word on the very cycle the 4th byte arrives.
  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    word      = word_q;
    word_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (accept && lane == LANE_W'(k)) word[8*k +: 8] = byte_data;
    end
    if (accept && (&lane)) word_done = 1'b1;
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader. Receives a 16-bit little-endian word count N
// followed by 4*N bytes, writes N little-endian 32-bit words to instruction
// memory at addresses 0..N-1, then releases the core from reset. A bad
// length or an inter-byte stall of TIMEOUT cycles parks the loader in ERR.
//   clk, rst                : clock, synchronous active-high reset.
//   byte_i / byte_valid_i   : input byte stream; byte_ready_o is the ready.
//   mem_we_o/addr_o/wdata_o : instruction-memory write port (1-cycle pulses).
//   core_rst_o              : core reset, released only after a full load.
//   busy_o                  : length accepted/being accepted, not RUN or ERR.
//   err_o                   : sticky error.
//   words_o                 : number of words written so far.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  new_len;
  logic [TO_W-1:0]   tcnt;
  logic              accept;
  logic              len_bad;
  logic              timeout_hit;
  logic              last_write;
  logic              counting;

  logic [31:0]       pack_word;
  logic              pack_done;
  logic [LANE_W-1:0] pack_lane_unused;  // lane position is not needed here

  assign byte_ready_o = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept       = byte_valid_i && byte_ready_o;
  assign busy_o       = (state == LEN1) || (state == DATA);
  assign err_o        = (state == ERR);
  assign core_rst_o   = (state != RUN);

  assign counting    = busy_o;
  assign new_len     = {byte_i, len_q[7:0]};
  assign len_bad     = (new_len == '0) || (new_len > LEN_W'(MAX_WORDS));
  // Fires on the idle cycle that would bring the counter to TIMEOUT.
  assign timeout_hit = counting && !accept && (tcnt == TO_W'(TIMEOUT - 1));
  // The pulse currently on the bus is the final word of the program.
  assign last_write  = mem_we_o && ((LEN_W'(words_o) + LEN_W'(1)) == len_q);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_data (byte_i),
    .accept    (accept && (state == DATA)),
    .clear     (state != DATA),
    .lane      (pack_lane_unused),
    .word      (pack_word),
    .word_done (pack_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LEN0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LEN0: if (accept) state_nxt = LEN1;
      LEN1: begin
        if (accept)           state_nxt = len_bad ? ERR : DATA;
        else if (timeout_hit) state_nxt = ERR;
      end
      DATA: begin
        if (last_write)       state_nxt = RUN;
        else if (timeout_hit) state_nxt = ERR;
      end
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      tcnt        <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      words_o     <= '0;
    end else begin
      // A completed word is registered and written on the following cycle;
      // address and data hold between pulses.
      mem_we_o <= pack_done;
      if (pack_done) begin
        mem_addr_o  <= words_o[ADDR_W-1:0];
        mem_wdata_o <= pack_word;
      end
      if (mem_we_o) words_o <= words_o + 1'b1;

      if (accept && state == LEN0) len_q[7:0]  <= byte_i;
      if (accept && state == LEN1) len_q[15:8] <= byte_i;

      if (counting && !accept) tcnt <= tcnt + TO_W'(1);
      else                     tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              err_o;
  logic [ADDR_W:0]   words_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .words_o      (words_o)
  );

  always #5 clk = ~clk;

  // Record every write pulse mid-cycle.
  always @(negedge clk) begin
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_wdata_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    byte_valid_i = 1'b0;
    cycles(2);
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Idle for 'gap' cycles, then present b for exactly one accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid_i = 1'b0;
    if (gap > 0) cycles(gap);
    byte_i = b;
    byte_valid_i = 1'b1;
    cycles(1);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (core_rst_o && n < 20) begin
      cycles(1);
      n++;
    end
    check(name, {31'd0, core_rst_o}, 32'd0);
  endtask

  // Drive random valid bytes for 50 cycles; no byte may be taken and no write issued.
  task automatic hammer(input string name);
    int bad = 0;
    for (int i = 0; i < 50; i++) begin
      byte_i = 8'($urandom);
      byte_valid_i = 1'b1;
      #1;
      if (byte_ready_o !== 1'b0 || mem_we_o !== 1'b0) bad++;
      cycles(1);
    end
    byte_valid_i = 1'b0;
    check(name, bad, 0);
  endtask

  typedef struct {
    logic [7:0]  b[4];
    logic [31:0] exp_word;
  } word_vec_t;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_err;
  } len_vec_t;

  word_vec_t wv[5];
  len_vec_t  lv[4];

  initial begin
    wv[0] = '{b: '{8'h13, 8'h05, 8'h50, 8'h00}, exp_word: 32'h00500513};
    wv[1] = '{b: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, exp_word: 32'hDEADBEEF};
    wv[2] = '{b: '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, exp_word: 32'hDDCCBBAA};
    wv[3] = '{b: '{8'hFF, 8'h00, 8'hFF, 8'h00}, exp_word: 32'h00FF00FF};
    wv[4] = '{b: '{8'h01, 8'h02, 8'h03, 8'h04}, exp_word: 32'h04030201};

    lv[0] = '{lo: 8'h00, hi: 8'h00, exp_err: 1'b1};  // N = 0
    lv[1] = '{lo: 8'h01, hi: 8'h01, exp_err: 1'b1};  // N = 257
    lv[2] = '{lo: 8'h00, hi: 8'h01, exp_err: 1'b0};  // N = 256
    lv[3] = '{lo: 8'h01, hi: 8'h00, exp_err: 1'b0};  // N = 1

    byte_i = 8'h00;
    byte_valid_i = 1'b0;
    rst = 1'b1;
    cycles(2);

    // Reset state
    check("rst core_rst", {31'd0, core_rst_o}, 32'd1);
    check("rst mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst addr", {24'd0, mem_addr_o}, 32'd0);
    check("rst wdata", mem_wdata_o, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst err", {31'd0, err_o}, 32'd0);
    check("rst words", {23'd0, words_o}, 32'd0);
    check("rst ready", {31'd0, byte_ready_o}, 32'd1);

    // Single-word loads with back-to-back bytes
    for (int i = 0; i < 5; i++) begin
      apply_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(wv[i].b[k], 0);
      // one cycle after the 4th byte: the write pulse
      check($sformatf("v%0d pulse", i), {31'd0, mem_we_o}, 32'd1);
      check($sformatf("v%0d addr", i), {24'd0, mem_addr_o}, 32'd0);
      check($sformatf("v%0d data", i), mem_wdata_o, wv[i].exp_word);
      check($sformatf("v%0d core_rst held", i), {31'd0, core_rst_o}, 32'd1);
      cycles(1);
      // two cycles after the last byte: core released
      check($sformatf("v%0d core_rst", i), {31'd0, core_rst_o}, 32'd0);
      check($sformatf("v%0d words", i), {23'd0, words_o}, 32'd1);
      check($sformatf("v%0d we low", i), {31'd0, mem_we_o}, 32'd0);
      check($sformatf("v%0d err", i), {31'd0, err_o}, 32'd0);
      check($sformatf("v%0d pulses", i), wr_addr_q.size(), 1);
    end

    // Length header table
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      send_byte(lv[i].lo, 0);
      send_byte(lv[i].hi, 0);
      check($sformatf("len%0d err", i), {31'd0, err_o}, {31'd0, lv[i].exp_err});
      check($sformatf("len%0d ready", i), {31'd0, byte_ready_o}, {31'd0, !lv[i].exp_err});
      check($sformatf("len%0d busy", i), {31'd0, busy_o}, {31'd0, !lv[i].exp_err});
      check($sformatf("len%0d core_rst", i), {31'd0, core_rst_o}, 32'd1);
      cycles(2);
      check($sformatf("len%0d no write", i), wr_addr_q.size(), 0);
    end

    // ERR is sticky and deaf to input (DUT is in ERR from N=257? no: last entry
    // was a good length, so set up ERR explicitly).
    apply_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    hammer("err hammer");
    check("err sticky", {31'd0, err_o}, 32'd1);
    check("err core_rst", {31'd0, core_rst_o}, 32'd1);
    check("err words", {23'd0, words_o}, 32'd0);
    check("err no write", wr_addr_q.size(), 0);

    // Two-word load with random gaps on valid
    begin
      logic [7:0] s[10];
      s = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
      apply_reset();
      for (int k = 0; k < 10; k++) send_byte(s[k], int'($urandom_range(0, 2)));
      wait_run("2w run");
      check("2w pulses", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
        check("2w addr0", {24'd0, wr_addr_q[0]}, 32'd0);
        check("2w data0", wr_data_q[0], 32'hDEADBEEF);
        check("2w addr1", {24'd0, wr_addr_q[1]}, 32'd1);
        check("2w data1", wr_data_q[1], 32'h12345678);
      end
      check("2w words", {23'd0, words_o}, 32'd2);
      check("2w err", {31'd0, err_o}, 32'd0);
    end

    // Timeout: exactly TIMEOUT idle cycles after a partial word
    apply_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    cycles(TIMEOUT - 1);
    check("to early err", {31'd0, err_o}, 32'd0);
    check("to early busy", {31'd0, busy_o}, 32'd1);
    cycles(1);
    check("to err", {31'd0, err_o}, 32'd1);
    check("to ready", {31'd0, byte_ready_o}, 32'd0);
    cycles(2);
    check("to no write", wr_addr_q.size(), 0);
    check("to core_rst", {31'd0, core_rst_o}, 32'd1);

    // One cycle short of the timeout, then finish the word
    apply_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    cycles(TIMEOUT - 1);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    check("short data", mem_wdata_o, 32'hDDCCBBAA);
    check("short pulse", {31'd0, mem_we_o}, 32'd1);
    cycles(1);
    check("short run", {31'd0, core_rst_o}, 32'd0);
    check("short err", {31'd0, err_o}, 32'd0);

    // Reset mid-load after 3 data bytes, then a fresh 1-word stream
    apply_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    apply_reset();
    check("mid busy", {31'd0, busy_o}, 32'd0);
    check("mid words", {23'd0, words_o}, 32'd0);
    check("mid ready", {31'd0, byte_ready_o}, 32'd1);
    check("mid core_rst", {31'd0, core_rst_o}, 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    wait_run("mid run");
    check("mid pulses", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check("mid addr", {24'd0, wr_addr_q[0]}, 32'd0);
      check("mid data", wr_data_q[0], 32'h77665544);
    end

    // RUN is sticky and deaf to input
    wr_addr_q.delete();
    wr_data_q.delete();
    hammer("run hammer");
    check("run core_rst", {31'd0, core_rst_o}, 32'd0);
    check("run words", {23'd0, words_o}, 32'd1);
    check("run addr hold", {24'd0, mem_addr_o}, 32'd0);
    check("run data hold", mem_wdata_o, 32'h77665544);
    check("run err", {31'd0, err_o}, 32'd0);
    check("run no write", wr_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
